// File: rtl/jk_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jk_pkg
// Description : Shared types and constants for the JK counter sequencer.
//               - state_t    : controller states (IDLE / RUN / DONE)
//               - JK_*       : two-bit {J,K} excitation codes for one cell
// Revision    : 1.0 - initial release
// ============================================================================
package jk_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

   // {J,K} excitation codes applied to a single JK cell
   localparam logic [1:0] JK_HOLD = 2'b00;
   localparam logic [1:0] JK_CLR  = 2'b01;
   localparam logic [1:0] JK_SET  = 2'b10;
   localparam logic [1:0] JK_TGL  = 2'b11;

endpackage : jk_pkg
`default_nettype wire

// File: rtl/jk_cell.sv
`default_nettype none
// ============================================================================
// Module      : jk_cell
// Description : One behavioural JK flip-flop with synchronous active-high
//               reset.
// Ports       : clk_i - clock (rising edge)
//               rst_i - synchronous active-high reset, clears q_o
//               j_i   - J excitation
//               k_i   - K excitation
//               q_o   - stored bit
// Revision    : 1.0 - initial release
// ============================================================================
module jk_cell
   import jk_pkg::*;
(
   input  logic clk_i,
   input  logic rst_i,
   input  logic j_i,
   input  logic k_i,
   output logic q_o
);

   logic q_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         q_q <= 1'b0;
      end else begin
         case ({j_i, k_i})
            JK_HOLD: q_q <= q_q;
            JK_CLR:  q_q <= 1'b0;
            JK_SET:  q_q <= 1'b1;
            JK_TGL:  q_q <= ~q_q;
            default: q_q <= q_q;
         endcase
      end
   end

   assign q_o = q_q;

endmodule : jk_cell
`default_nettype wire

// File: rtl/jk_count_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : jk_count_ctrl
// Description : Sequencer that owns the J/K inputs of a bank of W JK cells.
//               On an accepted start it loads the bank, then counts up or
//               down by toggle excitation until the terminal value is
//               reached (or forever in free-run mode).
// Ports       : Clk      - clock (rising edge)
//               reset    - synchronous active-high reset
//               start    - begin a sequence (IDLE only)
//               dir      - 0 up / 1 down, latched at start
//               free_run - ignore terminal value, latched at start
//               load_val - initial bank value
//               term_val - terminal value, latched at start
//               hold     - pause stepping in RUN
//               abort    - leave RUN without done
//               J, K     - per-bit excitation driven into the bank
//               Q        - bank state
//               busy     - high in RUN and DONE
//               done     - one-cycle pulse in DONE
// Revision    : 1.0 - initial release
// ============================================================================
module jk_count_ctrl
   import jk_pkg::*;
#(
   parameter int unsigned W                = 4,
   parameter bit          FREE_RUN_DEFAULT = 1'b0
)(
   input  logic         Clk,
   input  logic         reset,
   input  logic         start,
   input  logic         dir,
   input  logic         free_run,
   input  logic [W-1:0] load_val,
   input  logic [W-1:0] term_val,
   input  logic         hold,
   input  logic         abort,
   output logic [W-1:0] J,
   output logic [W-1:0] K,
   output logic [W-1:0] Q,
   output logic         busy,
   output logic         done
);

   state_t       state_q, state_d;
   logic         dir_q;
   logic         free_q;
   logic [W-1:0] term_q;
   logic         busy_q;
   logic         done_q;

   logic [W-1:0] tmask;
   logic [W-1:0] jx;
   logic [W-1:0] kx;
   logic [W-1:0] bank_q;

   // Toggle mask: bit i flips when every lower bit is 1 (up) or 0 (down).
   // Wrap-around at all-ones / zero follows naturally from this rule.
   always_comb begin
      logic carry;
      carry = 1'b1;
      tmask = '0;
      for (int i = 0; i < int'(W); i++) begin
         tmask[i] = carry;
         carry    = carry & (dir_q ? ~bank_q[i] : bank_q[i]);
      end
   end

   always_comb begin
      jx      = '0;
      kx      = '0;
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               jx      = load_val;
               kx      = ~load_val;
               state_d = ((load_val == term_val) && !free_run) ? DONE : RUN;
            end
         end
         RUN: begin
            // abort wins over hold and over termination
            if (abort) begin
               state_d = IDLE;
            end else if (!hold) begin
               jx = tmask;
               kx = tmask;
               if (!free_q && ((bank_q ^ tmask) == term_q)) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      // Keep the bank quiet while reset is asserted
      if (reset) begin
         jx = '0;
         kx = '0;
      end
   end

   always_ff @(posedge Clk) begin
      if (reset) begin
         state_q <= IDLE;
         dir_q   <= 1'b0;
         free_q  <= FREE_RUN_DEFAULT;
         term_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         if ((state_q == IDLE) && start) begin
            dir_q  <= dir;
            free_q <= free_run;
            term_q <= term_val;
         end
         busy_q <= (state_d != IDLE);
         done_q <= (state_d == DONE);
      end
   end

   generate
      for (genvar gi = 0; gi < int'(W); gi++) begin : g_cell
         jk_cell u_cell (
            .clk_i (Clk),
            .rst_i (reset),
            .j_i   (jx[gi]),
            .k_i   (kx[gi]),
            .q_o   (bank_q[gi])
         );
      end
   endgenerate

   assign J    = jx;
   assign K    = kx;
   assign Q    = bank_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule : jk_count_ctrl
`default_nettype wire
